// File: rtl/load_store_unit.sv
// load_store_unit
// Byte/halfword/word load-store front end for a word-wide data memory that has
// no byte enables. Loads extract and sign/zero-extend one lane of the word.
// Word stores write straight through. Sub-word stores read the word, replace
// one lane and write the merged word back.
// Optional feature macro: LSU_ALIGN_CHECK_EN. When it is defined, misaligned
// halfword/word requests are rejected with err. When it is undefined, the
// sub-size address bits are dropped and err stays 0.
module load_store_unit #(
    parameter int ADDR_W     = 18,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_WriteData,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    input  logic [31:0]       mem_ReadData
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_RMW_RD = 3'd2,
        S_RMW_WR = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    // Bit position of the addressed lane inside the memory word.
    function automatic logic [4:0] lane_shift(input logic [1:0] sz, input logic [1:0] boff);
        logic [4:0] sh;
        case (sz)
            2'b00:   sh = BIG_ENDIAN ? {~boff, 3'b000} : {boff, 3'b000};
            2'b01:   sh = BIG_ENDIAN ? {~boff[1], 4'b0000} : {boff[1], 4'b0000};
            default: sh = 5'd0;
        endcase
        return sh;
    endfunction

    // Extract the addressed lane and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] boff, input logic u);
        logic [31:0] lane;
        logic [31:0] res;
        lane = word >> lane_shift(sz, boff);
        case (sz)
            2'b00:   res = {{24{~u & lane[7]}}, lane[7:0]};
            2'b01:   res = {{16{~u & lane[15]}}, lane[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of a word with the low bits of the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] boff);
        logic [31:0] lane_mask;
        logic [4:0]  sh;
        case (sz)
            2'b00:   lane_mask = 32'h0000_00FF;
            2'b01:   lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        sh = lane_shift(sz, boff);
        return (word & ~(lane_mask << sh)) | ((wd & lane_mask) << sh);
    endfunction

    state_t              state_r;
    logic                we_r;
    logic [1:0]          size_r;
    logic                uns_r;
    logic [1:0]          boff_r;
    logic [31:0]         wdata_r;
    logic                ready_r;
    logic                done_r;
    logic                err_r;
    logic [31:0]         rdata_r;
    logic [ADDR_W-1:0]   mem_address_r;
    logic [31:0]         mem_wdata_r;
    logic                mem_write_r;
    logic                mem_read_r;

    logic [1:0]          boff_s;
    logic                misaligned_s;
    logic                subword_s;

    // Byte offset used for lane selection; address bits below the access size are dropped.
    always_comb begin
        case (size)
            2'b00:   boff_s = addr[1:0];
            2'b01:   boff_s = {addr[1], 1'b0};
            default: boff_s = 2'b00;
        endcase
    end

`ifdef LSU_ALIGN_CHECK_EN
    // A halfword must sit on an even address and a word on a multiple of four.
    always_comb begin
        case (size)
            2'b00:   misaligned_s = 1'b0;
            2'b01:   misaligned_s = addr[0];
            default: misaligned_s = (addr[1:0] != 2'b00);
        endcase
    end
`else
    assign misaligned_s = 1'b0;
`endif

    assign subword_s = ~size[1];

    // Address bits above the memory word address are deliberately ignored.
    generate
        if (ADDR_W < 30) begin : g_high_addr
            logic unused_s;
            assign unused_s = ^addr[31:ADDR_W+2];
        end
    endgenerate

    // Request sequencer: captures a request in IDLE and walks the access states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            we_r          <= 1'b0;
            size_r        <= 2'b00;
            uns_r         <= 1'b0;
            boff_r        <= 2'b00;
            wdata_r       <= 32'h0000_0000;
            ready_r       <= 1'b1;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            rdata_r       <= 32'h0000_0000;
            mem_address_r <= '0;
            mem_wdata_r   <= 32'h0000_0000;
            mem_write_r   <= 1'b0;
            mem_read_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    if (req) begin
                        we_r          <= we;
                        size_r        <= size;
                        uns_r         <= uns;
                        boff_r        <= boff_s;
                        wdata_r       <= wdata;
                        mem_address_r <= addr[ADDR_W+1:2];
                        ready_r       <= 1'b0;
                        if (misaligned_s) begin
                            // Rejected without touching memory.
                            state_r <= S_RESP;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                        end else if (we && subword_s) begin
                            state_r    <= S_RMW_RD;
                            mem_read_r <= 1'b1;
                        end else if (we) begin
                            state_r     <= S_ACCESS;
                            mem_write_r <= 1'b1;
                            mem_wdata_r <= wdata;
                        end else begin
                            state_r    <= S_ACCESS;
                            mem_read_r <= 1'b1;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (!we_r) begin
                        rdata_r <= load_extend(mem_ReadData, size_r, boff_r, uns_r);
                    end
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    done_r      <= 1'b1;
                    err_r       <= 1'b0;
                    state_r     <= S_RESP;
                end
                S_RMW_RD: begin
                    // The read word is captured already merged; it is the write data next cycle.
                    mem_wdata_r <= store_merge(mem_ReadData, wdata_r, size_r, boff_r);
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b1;
                    state_r     <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    mem_write_r <= 1'b0;
                    done_r      <= 1'b1;
                    err_r       <= 1'b0;
                    state_r     <= S_RESP;
                end
                S_RESP: begin
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    done_r      <= 1'b0;
                    err_r       <= 1'b0;
                    ready_r     <= 1'b1;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign ready         = ready_r;
    assign done          = done_r;
    assign err           = err_r;
    assign rdata         = rdata_r;
    assign mem_address   = mem_address_r;
    assign mem_WriteData = mem_wdata_r;
    // Gated by rst so that an access aborted by reset never commits.
    assign mem_MemWrite  = mem_write_r & ~rst;
    assign mem_MemRead   = mem_read_r & ~rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit (BIG_ENDIAN=1, ADDR_W=18)
// with a small word memory model behind it.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [17:0] mem_address;
    logic [31:0] mem_WriteData;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [31:0] mem_ReadData;

    logic [31:0] mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    int n_vec;
    int n_checks;
    int n_err;

    load_store_unit #(.ADDR_W(18), .BIG_ENDIAN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .size         (size),
        .uns          (uns),
        .addr         (addr),
        .wdata        (wdata),
        .ready        (ready),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .mem_address  (mem_address),
        .mem_WriteData(mem_WriteData),
        .mem_MemWrite (mem_MemWrite),
        .mem_MemRead  (mem_MemRead),
        .mem_ReadData (mem_ReadData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word memory: combinational read, write committed at the clock edge.
    assign mem_ReadData = mem[mem_address[7:0]];
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (mem_MemWrite) mem[mem_address[7:0]] <= mem_WriteData;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic        acc;
        logic [17:0] maddr;
        logic [31:0] rdata;
        logic [31:0] memword;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [1:0] s, input logic u,
                                input logic [31:0] a, input logic [31:0] d, input int l,
                                input logic e, input logic ac, input logic [17:0] ma,
                                input logic [31:0] rd, input logic [31:0] mw);
        vec_t v;
        v.we = w; v.size = s; v.uns = u; v.addr = a; v.wdata = d; v.lat = l;
        v.err = e; v.acc = ac; v.maddr = ma; v.rdata = rd; v.memword = mw;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issue one request from IDLE and observe it until done (bounded).
    task automatic do_req(input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic e, output logic rd, output logic wr,
                          output logic both, output logic [17:0] ma,
                          output logic dn_after, output logic rdy_after);
        lat = 0; e = 1'b0; rd = 1'b0; wr = 1'b0; both = 1'b0; ma = 18'd0;
        req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (mem_MemRead) rd = 1'b1;
            if (mem_MemWrite) wr = 1'b1;
            if (mem_MemRead && mem_MemWrite) both = 1'b1;
            if (mem_MemRead || mem_MemWrite) ma = mem_address;
            if (done) begin
                lat = c;
                e = err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        dn_after = done;
        rdy_after = ready;
    endtask

    vec_t        vt [20];
    int          lat;
    logic        e_s, rd_s, wr_s, both_s, dn_s, rdy_s;
    logic [17:0] ma_s;
    logic [31:0] cur_rdata;
    int          ndone;

    initial begin
        n_vec = 0; n_checks = 0; n_err = 0;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'h0; wdata = 32'h0; pre_we = 1'b0; pre_idx = 8'h0; pre_data = 32'h0;

        //              we   size  uns addr          wdata         lat err acc maddr   rdata         memword
        vt[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 2, 1'b0, 1'b1, 18'd4,  32'h0,        32'hDEADBEEF);
        vt[1]  = mk(1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        2, 1'b0, 1'b1, 18'd4,  32'hDEADBEEF, 32'h0);
        vt[2]  = mk(1'b0, 2'b00, 1'b0, 32'h20,       32'h0,        2, 1'b0, 1'b1, 18'd8,  32'hFFFFFF80, 32'h0);
        vt[3]  = mk(1'b0, 2'b00, 1'b1, 32'h20,       32'h0,        2, 1'b0, 1'b1, 18'd8,  32'h00000080, 32'h0);
        vt[4]  = mk(1'b0, 2'b00, 1'b0, 32'h22,       32'h0,        2, 1'b0, 1'b1, 18'd8,  32'h0000007F, 32'h0);
        vt[5]  = mk(1'b0, 2'b01, 1'b0, 32'h22,       32'h0,        2, 1'b0, 1'b1, 18'd8,  32'h00007F01, 32'h0);
        vt[6]  = mk(1'b0, 2'b01, 1'b0, 32'h20,       32'h0,        2, 1'b0, 1'b1, 18'd8,  32'hFFFF80FF, 32'h0);
        vt[7]  = mk(1'b0, 2'b01, 1'b1, 32'h20,       32'h0,        2, 1'b0, 1'b1, 18'd8,  32'h000080FF, 32'h0);
        vt[8]  = mk(1'b0, 2'b00, 1'b0, 32'h21,       32'h0,        2, 1'b0, 1'b1, 18'd8,  32'hFFFFFFFF, 32'h0);
        vt[9]  = mk(1'b0, 2'b00, 1'b1, 32'h23,       32'h0,        2, 1'b0, 1'b1, 18'd8,  32'h00000001, 32'h0);
        vt[10] = mk(1'b1, 2'b00, 1'b0, 32'h31,       32'h000000AA, 3, 1'b0, 1'b1, 18'd12, 32'h0,        32'h11AA3344);
        vt[11] = mk(1'b0, 2'b10, 1'b0, 32'h30,       32'h0,        2, 1'b0, 1'b1, 18'd12, 32'h11AA3344, 32'h0);
        vt[12] = mk(1'b1, 2'b01, 1'b0, 32'h32,       32'h0000BEEF, 3, 1'b0, 1'b1, 18'd12, 32'h0,        32'h11AABEEF);
        vt[13] = mk(1'b0, 2'b10, 1'b0, 32'h30,       32'h0,        2, 1'b0, 1'b1, 18'd12, 32'h11AABEEF, 32'h0);
        vt[14] = mk(1'b1, 2'b00, 1'b0, 32'h33,       32'hFFFFFF55, 3, 1'b0, 1'b1, 18'd12, 32'h0,        32'h11AABE55);
        vt[15] = mk(1'b0, 2'b11, 1'b1, 32'h10,       32'h0,        2, 1'b0, 1'b1, 18'd4,  32'hDEADBEEF, 32'h0);
        vt[16] = mk(1'b0, 2'b10, 1'b0, 32'hFFF00010, 32'h0,        2, 1'b0, 1'b1, 18'd4,  32'hDEADBEEF, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
        vt[17] = mk(1'b0, 2'b10, 1'b0, 32'h13,       32'h0,        1, 1'b1, 1'b0, 18'd0,  32'hDEADBEEF, 32'h0);
        vt[18] = mk(1'b0, 2'b01, 1'b1, 32'h23,       32'h0,        1, 1'b1, 1'b0, 18'd0,  32'hDEADBEEF, 32'h0);
        vt[19] = mk(1'b1, 2'b01, 1'b0, 32'h31,       32'h00001234, 1, 1'b1, 1'b0, 18'd0,  32'h0,        32'h11AABE55);
`else
        vt[17] = mk(1'b0, 2'b10, 1'b0, 32'h13,       32'h0,        2, 1'b0, 1'b1, 18'd4,  32'hDEADBEEF, 32'h0);
        vt[18] = mk(1'b0, 2'b01, 1'b1, 32'h23,       32'h0,        2, 1'b0, 1'b1, 18'd8,  32'h00007F01, 32'h0);
        vt[19] = mk(1'b1, 2'b01, 1'b0, 32'h31,       32'h00001234, 3, 1'b0, 1'b1, 18'd12, 32'h0,        32'h1234BE55);
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        chk("reset_ready", 0, {31'd0, ready}, 32'd1);
        chk("reset_done", 0, {31'd0, done}, 32'd0);
        chk("reset_err", 0, {31'd0, err}, 32'd0);
        chk("reset_rdata", 0, rdata, 32'h0);
        chk("reset_mem_address", 0, {14'd0, mem_address}, 32'd0);
        chk("reset_mem_wdata", 0, mem_WriteData, 32'h0);
        chk("reset_mem_en", 0, {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        preload(8'd8, 32'h80FF7F01);
        preload(8'd12, 32'h11223344);
        cur_rdata = 32'h0;

        // Table-driven vectors.
        for (int i = 0; i < 20; i++) begin
            do_req(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata,
                   lat, e_s, rd_s, wr_s, both_s, ma_s, dn_s, rdy_s);
            n_vec++;
            chk("latency", i, lat, vt[i].lat);
            chk("err", i, {31'd0, e_s}, {31'd0, vt[i].err});
            chk("mem_read_seen", i, {31'd0, rd_s},
                {31'd0, vt[i].acc & (~vt[i].we | ~vt[i].size[1])});
            chk("mem_write_seen", i, {31'd0, wr_s}, {31'd0, vt[i].acc & vt[i].we});
            chk("rd_wr_overlap", i, {31'd0, both_s}, 32'd0);
            if (vt[i].acc) chk("mem_address", i, {14'd0, ma_s}, {14'd0, vt[i].maddr});
            else chk("mem_address", i, 32'd0, 32'd0 + {31'd0, rd_s | wr_s});
            chk("done_one_cycle", i, {31'd0, dn_s}, 32'd0);
            chk("ready_after", i, {31'd0, rdy_s}, 32'd1);
            if (!vt[i].we && !vt[i].err) cur_rdata = vt[i].rdata;
            chk("rdata", i, rdata, cur_rdata);
            if (vt[i].we) chk("mem_word", i, mem[8'd12 & 8'hFF] & 32'h0 | mem[vt[i].addr[9:2]], vt[i].memword);
        end

        // Reset during the write cycle of a sub-word store.
        n_vec++;
        preload(8'd12, 32'h11223344);
        req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h30; wdata = 32'h77;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("rmw_wr_write_before_rst", 20, {31'd0, mem_MemWrite}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_gates_write", 20, {31'd0, mem_MemWrite}, 32'd0);
        chk("rst_gates_read", 20, {31'd0, mem_MemRead}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ready_after_rst", 20, {31'd0, ready}, 32'd1);
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk("no_done_after_abort", 20, ndone, 32'd0);
        chk("mem_unchanged_after_abort", 20, mem[12], 32'h11223344);
        chk("rdata_cleared_by_rst", 20, rdata, 32'h0);

        // Load with req held high while busy: exactly one done.
        n_vec++;
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10; wdata = 32'h0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 2) req = 1'b0;
            if (done) ndone++;
        end
        chk("held_req_load_dones", 21, ndone, 32'd1);
        chk("held_req_load_rdata", 21, rdata, 32'hDEADBEEF);

        // Sub-word store with req held high while busy: exactly one done, one write.
        n_vec++;
        req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h30; wdata = 32'h77;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 2) req = 1'b0;
            if (done) ndone++;
        end
        chk("held_req_store_dones", 22, ndone, 32'd1);
        chk("held_req_store_mem", 22, mem[12], 32'h77223344);
        chk("held_req_store_rdata", 22, rdata, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
